// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues one memory request at a time, buffers one
// word under decode stall, and handles taken-branch redirects and the flush pulse.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        flush
);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e      r_state, w_state_d;
    logic        r_imem_req;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_imem_addr, w_imem_addr_d;
    logic        r_instr_valid, w_instr_valid_d;
    logic [31:0] r_instr, w_instr_d;
    logic [31:0] r_instr_pc, w_instr_pc_d;
    logic        r_flush;
    logic        r_hold_valid, w_hold_valid_d;
    logic [31:0] r_hold_data, w_hold_data_d;
    logic [31:0] r_hold_pc, w_hold_pc_d;
    logic        w_keep;
    logic        w_free;

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_imem_addr_d   = r_imem_addr;
        w_instr_valid_d = r_instr_valid;
        w_instr_d       = r_instr;
        w_instr_pc_d    = r_instr_pc;
        w_hold_valid_d  = r_hold_valid;
        w_hold_data_d   = r_hold_data;
        w_hold_pc_d     = r_hold_pc;
        w_free          = 1'b0;

        // A fetch completing in REQ is kept unless a redirect lands on the same edge.
        w_keep = (r_state == StReq) && imem_ack && !redirect_valid;

        if (redirect_valid) begin
            w_instr_valid_d = 1'b0;
            w_hold_valid_d  = 1'b0;
            w_pc_d          = {redirect_pc[31:2], 2'b00};
        end else if (w_keep) begin
            w_pc_d = r_imem_addr + 32'd4;
            if (!stall && !r_hold_valid) begin
                w_instr_valid_d = 1'b1;
                w_instr_d       = imem_rdata;
                w_instr_pc_d    = r_imem_addr;
            end else begin
                w_hold_valid_d = 1'b1;
                w_hold_data_d  = imem_rdata;
                w_hold_pc_d    = r_imem_addr;
            end
        end else if (!stall) begin
            if (r_hold_valid) begin
                w_instr_valid_d = 1'b1;
                w_instr_d       = r_hold_data;
                w_instr_pc_d    = r_hold_pc;
                w_hold_valid_d  = 1'b0;
            end else begin
                w_instr_valid_d = 1'b0;
            end
        end

        unique case (r_state)
            StIdle: w_free = 1'b1;
            StReq: begin
                w_free = imem_ack;
                if (!imem_ack && redirect_valid) begin
                    w_state_d = StDrop;
                end
            end
            StDrop:  w_free = imem_ack;
            default: w_free = 1'b1;
        endcase

        // The bus is free for a new request only once any outstanding handshake completes.
        if (w_free) begin
            if (!stall && !w_hold_valid_d) begin
                w_state_d     = StReq;
                w_imem_addr_d = w_pc_d;
            end else begin
                w_state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_imem_req    <= 1'b0;
            r_pc          <= RESET_PC;
            r_imem_addr   <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_flush       <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_data   <= 32'd0;
            r_hold_pc     <= 32'd0;
        end else begin
            r_state       <= w_state_d;
            r_imem_req    <= (w_state_d != StIdle);
            r_pc          <= w_pc_d;
            r_imem_addr   <= w_imem_addr_d;
            r_instr_valid <= w_instr_valid_d;
            r_instr       <= w_instr_d;
            r_instr_pc    <= w_instr_pc_d;
            r_flush       <= redirect_valid;
            r_hold_valid  <= w_hold_valid_d;
            r_hold_data   <= w_hold_data_d;
            r_hold_pc     <= w_hold_pc_d;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign flush       = r_flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked by a
// program-order scoreboard of (pc, word) pairs fed from a fetch-stream model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;

    int total = 0;
    int bad = 0;
    int delivered = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    assign imem_rdata = imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .flush         (flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } item_t;

    item_t       q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_doom = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_addr = 32'd0;
    bit          e_rst = 1'b1;
    bit          e_stall = 1'b0;
    bit          e_redir = 1'b0;

    // Fetch-stream model: sequential addresses from the last redirect target; words
    // fetched before a redirect (or whose request straddles one) never reach decode.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_pc   = RESET_PC;
                m_doom = 1'b0;
                m_pend = 1'b0;
                e_rst  = 1'b1;
                e_stall = 1'b0;
                e_redir = 1'b0;
            end else begin
                e_rst   = 1'b0;
                e_stall = stall;
                e_redir = redirect_valid;
                if (m_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, m_pend_addr);
                end
                if (imem_req && imem_ack) begin
                    if (!(m_doom || redirect_valid)) begin
                        chk("fetch_addr", imem_addr, m_pc);
                        q.push_back('{pc: m_pc, data: memf(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                    m_doom = 1'b0;
                end
                if (redirect_valid) begin
                    q.delete();
                    m_pc = {redirect_pc[31:2], 2'b00};
                    if (imem_req && !imem_ack) m_doom = 1'b1;
                end
                m_pend      = imem_req && !imem_ack;
                m_pend_addr = imem_addr;
            end
        end
    end

    // Monitor: after each edge, compare decode outputs against the scoreboard.
    initial begin
        item_t it;
        bit    exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && !e_rst) begin
                chk("flush", 32'(flush), 32'(e_redir));
                if (e_redir) begin
                    chk("valid_after_redirect", 32'(instr_valid), 32'd0);
                end else if (!e_stall) begin
                    exp_v = (q.size() > 0);
                    chk("valid", 32'(instr_valid), 32'(exp_v));
                    if (exp_v && instr_valid) begin
                        it = q.pop_front();
                        chk("instr_pc", instr_pc, it.pc);
                        chk("instr", instr, it.data);
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_ack = 1'b0;
        repeat (3) tick();
        imem_ack = 1'b1;
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);

        // Streaming with ack tied high: one instruction per cycle.
        rst = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("stream_addr", imem_addr, RESET_PC + 32'(4 * k));
            chk("stream_pc", instr_pc, RESET_PC + 32'(4 * (k - 1)));
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_instr", instr, memf(RESET_PC + 32'(4 * (k - 1))));
        end

        // Stall across completion: word parks in the hold buffer.
        stall = 1'b1;
        tick();
        chk("stall_hold_pc", instr_pc, 32'd12);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        tick();
        tick();
        chk("stall_req2", 32'(imem_req), 32'd0);
        chk("stall_hold_pc2", instr_pc, 32'd12);
        stall = 1'b0;
        tick();
        chk("unstall_pc", instr_pc, 32'd16);
        chk("unstall_instr", instr, memf(32'd16));
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'd20);

        // Redirect while a request at 0x10 is outstanding.
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        chk("rd10_addr", imem_addr, 32'h10);
        chk("rd10_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        redirect_pc = 32'h200;
        tick();
        chk("drop_flush", 32'(flush), 32'd1);
        chk("drop_addr", imem_addr, 32'h10);
        redirect_valid = 1'b0;
        tick();
        chk("drop_flush_end", 32'(flush), 32'd0);
        chk("drop_addr2", imem_addr, 32'h10);
        chk("drop_req", 32'(imem_req), 32'd1);
        tick();
        chk("drop_addr3", imem_addr, 32'h10);
        chk("drop_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("after_drop_addr", imem_addr, 32'h200);
        chk("after_drop_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("target_pc", instr_pc, 32'h200);

        // Redirect coincident with ack: the acked word is discarded.
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("rd40_addr", imem_addr, 32'h40);
        redirect_pc = 32'h103;
        tick();
        chk("coinc_valid", 32'(instr_valid), 32'd0);
        chk("coinc_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        tick();
        chk("coinc_next_pc", instr_pc, 32'h100);
        chk("coinc_next_instr", instr, memf(32'h100));

        // Address wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset with a request pending.
        imem_ack = 1'b0;
        tick();
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("arst_ack_ignored", 32'(imem_req), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, RESET_PC);

        // Randomized traffic, checked by the scoreboard.
        for (int n = 0; n < 4000; n++) begin
            stall = ($urandom % 4) == 0;
            imem_ack = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            if (($urandom % 4) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = $urandom;
            tick();
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        repeat (5) tick();
        chk("progress", 32'(delivered > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (word-aligned).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-005 redirect_valid  in  1  one-cycle pulse from the branch/jump unit, taken branch or jump.
REQ-006 redirect_pc  in  32  target address, qualified by redirect_valid.
REQ-007 imem_req  out  1  instruction fetch request, registered.
REQ-008 imem_addr  out  32  fetch address, registered, stable while imem_req=1.
REQ-009 imem_ack  in  1  fetch complete; may be asserted in the same cycle as imem_req or any later cycle.
REQ-010 imem_rdata  in  32  fetched word, valid only when imem_req=1 and imem_ack=1.
REQ-011 instr_valid  out  1  instr/instr_pc hold a live instruction for decode.
REQ-012 instr  out  32  instruction word.
REQ-013 instr_pc  out  32  address of instr.
REQ-014 flush  out  1  registered one-cycle pulse that kills younger instructions in the decode/execute stages.

Function
REQ-015 The block SHALL implement states IDLE (no request), REQ (request outstanding) and DROP (request outstanding, data to be discarded).
REQ-016 The block SHALL keep imem_req=1 and imem_addr unchanged in REQ and DROP until the edge where imem_ack=1, so that no handshake is ever abandoned.
REQ-017 A fetch SHALL complete at an edge where imem_req=1 and imem_ack=1; in REQ, pc SHALL become imem_addr+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
REQ-018 On completion in REQ with stall=0 and the hold buffer empty, the block SHALL load instr<=imem_rdata, instr_pc<=imem_addr and instr_valid<=1 at that edge.
REQ-019 On completion in REQ with stall=1, the block SHALL capture the data into a one-entry hold buffer and leave the outputs unchanged.
REQ-020 With stall=1, the block SHALL hold instr, instr_pc and instr_valid.
REQ-021 With stall=0 and no completing fetch, the block SHALL move the hold buffer to the outputs if it is full; otherwise it SHALL clear instr_valid.
REQ-022 The block SHALL move to REQ with imem_addr<=pc only at an edge where stall=0 and the hold buffer will be empty after that edge; otherwise it SHALL go to or stay in IDLE with imem_req=0.
REQ-023 Back-to-back REQ SHALL be allowed, giving one instruction per cycle when imem_ack is asserted in the request cycle.
REQ-024 On redirect_valid=1, regardless of stall, the block SHALL:
  - clear instr_valid and the hold buffer;
  - set pc<=redirect_pc with bits [1:0] forced to 0;
  - assert flush for exactly the following cycle.
REQ-025 If redirect arrives in REQ without imem_ack, the block SHALL go to DROP; when the DROP fetch completes, its data SHALL be discarded, pc SHALL NOT be incremented, and the next request SHALL target the redirected pc.
REQ-026 If redirect coincides with imem_ack, the returned data SHALL be discarded and the next request SHALL be to the redirected pc on the following cycle.
REQ-027 A redirect during DROP SHALL overwrite pc; the latest target wins.
REQ-028 In DROP the block SHALL NOT assert instr_valid for the dropped data.

Reset
REQ-029 While rst=1, the block SHALL hold: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, flush=0, hold buffer empty.
REQ-030 Reset asserted mid-fetch SHALL abandon the request immediately; any imem_ack during reset SHALL be ignored.
REQ-031 The first request SHALL be issued at the first rising edge after rst deasserts (imem_req=1, imem_addr=RESET_PC), provided stall=0.

Verification
REQ-032 Reset release, stall=0, imem_ack tied 1 -> imem_addr 0,4,8,... on consecutive cycles; instr_pc trails imem_addr by one cycle with instr_valid=1.
REQ-033 Ack on cycle N with stall=1 during cycles N..N+2 -> outputs hold the old instruction, the word at N goes to the hold buffer, imem_req=0; after stall drops, the held word appears and the next request goes to pc+4.
REQ-034 Request at 0x10, ack delayed 3 cycles, redirect_valid with redirect_pc=0x200 in cycle 1 -> flush pulse, imem_addr stays 0x10 until ack, data dropped, next request to 0x200, instr_valid=0 throughout.
REQ-035 Redirect to 0x103 coincident with ack of 0x40 -> 0x40 data never becomes valid; next imem_addr=0x100.
REQ-036 pc=0xFFFF_FFFC fetch acked -> next imem_addr=0x0.
REQ-037 rst asserted while imem_req=1 and ack pending -> imem_req drops asynchronously, all outputs return to reset values, and the first fetch after release is to RESET_PC.
